// File: rtl/kitchen_timer_core_pkg.sv
// Shared state encoding and BCD digit limits for the kitchen timer countdown core.
package kitchen_timer_core_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } kt_state_e;

  localparam int DIGIT_W      = 4;
  localparam int DIGIT_MAX    = 9;
  localparam int SEC_TENS_MAX = 5;
endpackage

// File: rtl/kitchen_timer_core_digit.sv
// One BCD digit with wrap-around increment/decrement; carry/borrow feed the next digit.
module kt_bcd_digit
  import kitchen_timer_core_pkg::*;
#(
  parameter int MAX = DIGIT_MAX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               dec,
  input  logic               clr,
  output logic [DIGIT_W-1:0] q,
  output logic               carry,
  output logic               borrow
);
  localparam logic [DIGIT_W-1:0] QMAX = DIGIT_W'(MAX);

  assign carry  = (q == QMAX) & inc;
  assign borrow = (q == '0) & dec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= '0;
    else if (clr) q <= '0;
    else if (inc) q <= (q == QMAX) ? '0 : q + 1'b1;
    else if (dec) q <= (q == '0) ? QMAX : q - 1'b1;
  end
endmodule

// File: rtl/kitchen_timer_core.sv
// Kitchen timer countdown core: MM:SS BCD count, run/pause FSM and timed alarm.
module kitchen_timer_core
  import kitchen_timer_core_pkg::*;
#(
  parameter int ALARM_SEC = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       key_start,
  input  logic       key_min,
  input  logic       key_sec,
  input  logic       key_clr,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       alarm
);
  kt_state_e  state;
  logic [7:0] acnt;

  logic [DIGIT_W-1:0] so, st, mo, mt;
  logic so_c, so_b, st_c, st_b, mo_c, mo_b, mt_c, mt_b;
  logic inc_sec, inc_min, dec_en, time_nz, at_one;
  logic unused_flags;

  assign sec_bcd = {st, so};
  assign min_bcd = {mt, mo};
  assign time_nz = |{min_bcd, sec_bcd};
  assign at_one  = (min_bcd == 8'h00) && (sec_bcd == 8'h01);

  // key_start outranks the setting keys and the tick; key_clr outranks everything
  assign inc_sec = (state == ST_IDLE) && key_sec && !key_start && !key_clr;
  assign inc_min = (state == ST_IDLE) && key_min && !key_start && !key_clr;
  assign dec_en  = (state == ST_RUN) && tick && !key_start && !key_clr;

  // Seconds carry stops at sec_tens so setting seconds never bumps the minutes
  kt_bcd_digit #(.MAX(DIGIT_MAX)) u_sec_ones (
    .clk(clk), .rst(rst), .inc(inc_sec), .dec(dec_en), .clr(key_clr),
    .q(so), .carry(so_c), .borrow(so_b));
  kt_bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .rst(rst), .inc(so_c), .dec(so_b), .clr(key_clr),
    .q(st), .carry(st_c), .borrow(st_b));
  kt_bcd_digit #(.MAX(DIGIT_MAX)) u_min_ones (
    .clk(clk), .rst(rst), .inc(inc_min), .dec(st_b), .clr(key_clr),
    .q(mo), .carry(mo_c), .borrow(mo_b));
  kt_bcd_digit #(.MAX(DIGIT_MAX)) u_min_tens (
    .clk(clk), .rst(rst), .inc(mo_c), .dec(mo_b), .clr(key_clr),
    .q(mt), .carry(mt_c), .borrow(mt_b));

  assign unused_flags = ^{st_c, mt_c, mt_b};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      acnt    <= '0;
      running <= 1'b0;
      alarm   <= 1'b0;
    end else if (key_clr) begin
      state   <= ST_IDLE;
      acnt    <= '0;
      running <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (key_start && time_nz) begin
          state   <= ST_RUN;
          running <= 1'b1;
        end
        ST_RUN: begin
          if (key_start) begin
            state   <= ST_PAUSE;
            running <= 1'b0;
          end else if (tick && at_one) begin
            state   <= ST_ALARM;
            acnt    <= '0;
            running <= 1'b0;
            alarm   <= 1'b1;
          end
        end
        ST_PAUSE: if (key_start) begin
          state   <= ST_RUN;
          running <= 1'b1;
        end
        ST_ALARM: begin
          if (key_start) begin
            state <= ST_IDLE;
            acnt  <= '0;
            alarm <= 1'b0;
          end else if (tick) begin
            if (acnt == 8'(ALARM_SEC - 1)) begin
              state <= ST_IDLE;
              acnt  <= '0;
              alarm <= 1'b0;
            end else begin
              acnt <= acnt + 8'd1;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          running <= 1'b0;
          alarm   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_kitchen_timer_core.sv
// Directed vector table plus hand sequences for the kitchen timer core (ALARM_SEC=3).
module tb_kitchen_timer_core;
  logic       clk = 1'b0;
  logic       rst;
  logic       tick, key_start, key_min, key_sec, key_clr;
  logic [7:0] min_bcd, sec_bcd;
  logic       running, alarm;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [4:0] K_NONE = 5'b00000;
  localparam logic [4:0] K_CLR  = 5'b10000;
  localparam logic [4:0] K_ST   = 5'b01000;
  localparam logic [4:0] K_TK   = 5'b00100;
  localparam logic [4:0] K_MN   = 5'b00010;
  localparam logic [4:0] K_SC   = 5'b00001;

  typedef struct {
    string      name;
    logic [4:0] keys;
    logic [7:0] emin;
    logic [7:0] esec;
    logic       erun;
    logic       ealm;
  } vec_t;

  vec_t vq[$];

  kitchen_timer_core #(.ALARM_SEC(3)) dut (
    .clk(clk), .rst(rst), .tick(tick), .key_start(key_start),
    .key_min(key_min), .key_sec(key_sec), .key_clr(key_clr),
    .min_bcd(min_bcd), .sec_bcd(sec_bcd), .running(running), .alarm(alarm));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] emin, input logic [7:0] esec,
                       input logic erun, input logic ealm);
    n_cmp++;
    if (min_bcd !== emin || sec_bcd !== esec || running !== erun || alarm !== ealm) begin
      n_bad++;
      $display("FAIL %s: got %h:%h run=%b alm=%b, want %h:%h run=%b alm=%b",
               name, min_bcd, sec_bcd, running, alarm, emin, esec, erun, ealm);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read at the same offset.
  task automatic step(input logic [4:0] k);
    {key_clr, key_start, tick, key_min, key_sec} = k;
    @(posedge clk);
    #1;
    {key_clr, key_start, tick, key_min, key_sec} = K_NONE;
  endtask

  task automatic add(input string n, input logic [4:0] k, input logic [7:0] m,
                     input logic [7:0] s, input logic r, input logic a);
    vq.push_back('{n, k, m, s, r, a});
  endtask

  initial begin
    rst = 1'b1;
    {key_clr, key_start, tick, key_min, key_sec} = K_NONE;

    // Table: set/borrow, zero start, ignored keys, expiry, clear priority
    add("zero_start",  K_ST,         8'h00, 8'h00, 0, 0);
    add("tick_idle0",  K_TK,         8'h00, 8'h00, 0, 0);
    add("set_min",     K_MN,         8'h01, 8'h00, 0, 0);
    for (int i = 1; i <= 5; i++) add("set_sec", K_SC, 8'h01, 8'(i), 0, 0);
    add("start",       K_ST,         8'h01, 8'h05, 1, 0);
    for (int i = 4; i >= 0; i--) add("count", K_TK, 8'h01, 8'(i), 1, 0);
    add("borrow_min",  K_TK,         8'h00, 8'h59, 1, 0);
    add("min_in_run",  K_MN,         8'h00, 8'h59, 1, 0);
    add("clr_tick",    K_CLR | K_TK, 8'h00, 8'h00, 0, 0);
    add("min_sec_both",K_MN | K_SC,  8'h01, 8'h01, 0, 0);
    add("tick_idle",   K_TK,         8'h01, 8'h01, 0, 0);
    add("start_wins",  K_ST | K_SC,  8'h01, 8'h01, 1, 0);
    add("clr_run",     K_CLR,        8'h00, 8'h00, 0, 0);
    add("set_2s_a",    K_SC,         8'h00, 8'h01, 0, 0);
    add("set_2s_b",    K_SC,         8'h00, 8'h02, 0, 0);
    add("start_2s",    K_ST,         8'h00, 8'h02, 1, 0);
    add("exp_t1",      K_TK,         8'h00, 8'h01, 1, 0);
    add("expire",      K_TK,         8'h00, 8'h00, 0, 1);
    add("alarm_key",   K_SC,         8'h00, 8'h00, 0, 1);
    add("alarm_t1",    K_TK,         8'h00, 8'h00, 0, 1);
    add("alarm_t2",    K_TK,         8'h00, 8'h00, 0, 1);
    add("alarm_done",  K_TK,         8'h00, 8'h00, 0, 0);
    add("set_1s",      K_SC,         8'h00, 8'h01, 0, 0);
    add("start_1s",    K_ST,         8'h00, 8'h01, 1, 0);
    add("expire2",     K_TK,         8'h00, 8'h00, 0, 1);
    add("alarm_clrst", K_CLR | K_ST, 8'h00, 8'h00, 0, 0);
    add("idle_after",  K_ST,         8'h00, 8'h00, 0, 0);
    add("set_1s_b",    K_SC,         8'h00, 8'h01, 0, 0);
    add("start_1s_b",  K_ST,         8'h00, 8'h01, 1, 0);
    add("expire3",     K_TK,         8'h00, 8'h00, 0, 1);
    add("alarm_ack",   K_ST,         8'h00, 8'h00, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 8'h00, 8'h00, 0, 0);
    rst = 1'b0;

    foreach (vq[i]) begin
      step(vq[i].keys);
      check($sformatf("%s[%0d]", vq[i].name, i), vq[i].emin, vq[i].esec, vq[i].erun, vq[i].ealm);
    end

    // Seconds wrap without carry, minutes wrap at 99
    for (int i = 0; i < 10; i++) step(K_SC);
    check("sec_10", 8'h00, 8'h10, 0, 0);
    for (int i = 0; i < 49; i++) step(K_SC);
    check("sec_59", 8'h00, 8'h59, 0, 0);
    step(K_SC);
    check("sec_wrap", 8'h00, 8'h00, 0, 0);
    for (int i = 0; i < 99; i++) step(K_MN);
    check("min_99", 8'h99, 8'h00, 0, 0);
    step(K_MN);
    check("min_wrap", 8'h00, 8'h00, 0, 0);

    // Minute-tens borrow: 10:00 -> 09:59
    for (int i = 0; i < 10; i++) step(K_MN);
    step(K_ST);
    step(K_TK);
    check("borrow_tens", 8'h09, 8'h59, 1, 0);
    step(K_CLR);

    // Pause collision at 00:10
    for (int i = 0; i < 10; i++) step(K_SC);
    step(K_ST);
    check("run_10", 8'h00, 8'h10, 1, 0);
    step(K_TK | K_ST);
    check("pause_drop", 8'h00, 8'h10, 0, 0);
    for (int i = 0; i < 3; i++) step(K_TK);
    step(K_MN);
    check("pause_hold", 8'h00, 8'h10, 0, 0);
    step(K_ST);
    check("resume", 8'h00, 8'h10, 1, 0);
    step(K_TK);
    check("resume_tick", 8'h00, 8'h09, 1, 0);
    step(K_CLR);

    // Asynchronous reset mid-RUN at 03:27
    for (int i = 0; i < 3; i++) step(K_MN);
    for (int i = 0; i < 27; i++) step(K_SC);
    step(K_ST);
    check("run_0327", 8'h03, 8'h27, 1, 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst", 8'h00, 8'h00, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(K_TK);
    check("post_rst_tick", 8'h00, 8'h00, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
